// File: rtl/hilo_acc.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_acc
//  Description : HI/LO accumulator register unit. MULT writeback, HI/LO moves
//                and reads, and 2-cycle split-carry multiply-accumulate.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_acc #(
    parameter int W = 32
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Valid,
    input  logic             ACCEn,
    input  logic [5:0]       Func,
    input  logic [2*W-1:0]   Product,
    input  logic [W-1:0]     RsData,
    output logic             Busy,
    output logic [W-1:0]     Result,
    output logic             ResultValid,
    output logic [W-1:0]     Hi,
    output logic [W-1:0]     Lo
);

    localparam logic [5:0] C_MADD  = 6'b000000;
    localparam logic [5:0] C_MADDU = 6'b000001;
    localparam logic [5:0] C_MSUB  = 6'b000100;
    localparam logic [5:0] C_MSUBU = 6'b000101;
    localparam logic [5:0] C_MULT  = 6'b011000;
    localparam logic [5:0] C_MULTU = 6'b011001;
    localparam logic [5:0] C_MFHI  = 6'b010000;
    localparam logic [5:0] C_MTHI  = 6'b010001;
    localparam logic [5:0] C_MFLO  = 6'b010010;
    localparam logic [5:0] C_MTLO  = 6'b010011;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ADDHI = 1'b1
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_result;
    logic           r_result_valid;
    logic           r_busy;
    logic           r_carry;
    logic [W-1:0]   r_phi;
    logic           r_sub_op;

    logic           w_accept;
    logic [W:0]     w_lo_add;
    logic [W:0]     w_lo_sub;
    logic [W-1:0]   w_carry_ext;

    assign w_accept    = Valid && !r_busy;
    // Bit W of the 33-bit sum is the carry; of the 33-bit difference, the borrow.
    assign w_lo_add    = {1'b0, r_lo} + {1'b0, Product[W-1:0]};
    assign w_lo_sub    = {1'b0, r_lo} - {1'b0, Product[W-1:0]};
    assign w_carry_ext = {{(W-1){1'b0}}, r_carry};

    always_ff @(posedge Clock or posedge nReset) begin
        if (nReset) begin
            r_state        <= IDLE;
            r_hi           <= '0;
            r_lo           <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_carry        <= 1'b0;
            r_phi          <= '0;
            r_sub_op       <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && ACCEn) begin
                        case (Func)
                            C_MADD, C_MADDU: begin
                                {r_carry, r_lo} <= w_lo_add;
                                r_phi           <= Product[2*W-1:W];
                                r_sub_op        <= 1'b0;
                                r_state         <= ADDHI;
                                r_busy          <= 1'b1;
                            end
                            C_MSUB, C_MSUBU: begin
                                {r_carry, r_lo} <= w_lo_sub;
                                r_phi           <= Product[2*W-1:W];
                                r_sub_op        <= 1'b1;
                                r_state         <= ADDHI;
                                r_busy          <= 1'b1;
                            end
                            default: ;
                        endcase
                    end else if (w_accept) begin
                        case (Func)
                            C_MULT, C_MULTU: begin
                                r_hi <= Product[2*W-1:W];
                                r_lo <= Product[W-1:0];
                            end
                            C_MTHI: r_hi <= RsData;
                            C_MTLO: r_lo <= RsData;
                            C_MFHI: begin
                                r_result       <= r_hi;
                                r_result_valid <= 1'b1;
                            end
                            C_MFLO: begin
                                r_result       <= r_lo;
                                r_result_valid <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ADDHI: begin
                    if (r_sub_op)
                        r_hi <= r_hi - r_phi - w_carry_ext;
                    else
                        r_hi <= r_hi + r_phi + w_carry_ext;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy        = r_busy;
    assign Result      = r_result;
    assign ResultValid = r_result_valid;
    assign Hi          = r_hi;
    assign Lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_acc
//  Description : Directed self-checking bench for hilo_acc.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_acc;

    logic        Clock = 1'b0;
    logic        nReset = 1'b1;
    logic        Valid = 1'b0;
    logic        ACCEn = 1'b0;
    logic [5:0]  Func = 6'b0;
    logic [63:0] Product = 64'b0;
    logic [31:0] RsData = 32'b0;
    logic        Busy;
    logic [31:0] Result;
    logic        ResultValid;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int vectors = 0;
    int miscompares = 0;

    hilo_acc #(.W(32)) dut (
        .Clock(Clock), .nReset(nReset), .Valid(Valid), .ACCEn(ACCEn),
        .Func(Func), .Product(Product), .RsData(RsData), .Busy(Busy),
        .Result(Result), .ResultValid(ResultValid), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clock = ~Clock;

    task automatic drive(input logic v, input logic acc, input logic [5:0] f,
                         input logic [63:0] p, input logic [31:0] rs);
        Valid = v; ACCEn = acc; Func = f; Product = p; RsData = rs;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 6'b0, 64'b0, 32'b0);
        nReset = 1'b1;
        #12;
        vectors++;
        if ({Busy, ResultValid, Hi, Lo, Result} !== 98'b0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b rv=%b hi=%h lo=%h res=%h want all 0",
                     Busy, ResultValid, Hi, Lo, Result);
        end
        @(negedge Clock);
        nReset = 1'b0;
        drive(1'b1, 1'b0, 6'b010000, 64'b0, 32'b0);   // MFHI
        step();
        vectors++;
        if (ResultValid !== 1'b1 || Result !== 32'h0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mfhi: got rv=%b res=%h busy=%b want rv=1 res=0 busy=0",
                     ResultValid, Result, Busy);
        end
        drive(1'b1, 1'b0, 6'b010010, 64'b0, 32'b0);   // MFLO
        step();
        vectors++;
        if (ResultValid !== 1'b1 || Result !== 32'h0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mflo: got rv=%b res=%h busy=%b want rv=1 res=0 busy=0",
                     ResultValid, Result, Busy);
        end
        drive(1'b0, 1'b0, 6'b0, 64'b0, 32'b0);
        step();
        vectors++;
        if (ResultValid !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rv_pulse: got rv=%b busy=%b want rv=0 busy=0", ResultValid, Busy);
        end
    endtask

    task automatic test_mult();
        drive(1'b1, 1'b0, 6'b011000, 64'h12345678_9ABCDEF0, 32'b0);
        step();
        vectors++;
        if (Hi !== 32'h12345678 || Lo !== 32'h9ABCDEF0) begin
            miscompares++;
            $display("FAIL mult_write: got hi=%h lo=%h want 12345678 9abcdef0", Hi, Lo);
        end
        drive(1'b1, 1'b0, 6'b010000, 64'b0, 32'b0);
        step();
        vectors++;
        if (ResultValid !== 1'b1 || Result !== 32'h12345678) begin
            miscompares++;
            $display("FAIL mult_mfhi: got rv=%b res=%h want rv=1 res=12345678", ResultValid, Result);
        end
        drive(1'b1, 1'b0, 6'b010010, 64'b0, 32'b0);
        step();
        vectors++;
        if (ResultValid !== 1'b1 || Result !== 32'h9ABCDEF0) begin
            miscompares++;
            $display("FAIL mult_mflo: got rv=%b res=%h want rv=1 res=9abcdef0", ResultValid, Result);
        end
    endtask

    task automatic test_madd_carry();
        drive(1'b1, 1'b0, 6'b010011, 64'b0, 32'hFFFFFFFF);   // MTLO
        step();
        drive(1'b1, 1'b0, 6'b010001, 64'b0, 32'h00000001);   // MTHI
        step();
        vectors++;
        if (Hi !== 32'h1 || Lo !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL mt_moves: got hi=%h lo=%h want 00000001 ffffffff", Hi, Lo);
        end
        drive(1'b1, 1'b1, 6'b000000, 64'h00000000_00000001, 32'b0);
        step();
        vectors++;
        if (Busy !== 1'b1 || Lo !== 32'h0 || Hi !== 32'h1) begin
            miscompares++;
            $display("FAIL madd_first: got busy=%b hi=%h lo=%h want busy=1 hi=1 lo=0", Busy, Hi, Lo);
        end
        drive(1'b0, 1'b0, 6'b0, 64'b0, 32'b0);
        step();
        vectors++;
        if (Busy !== 1'b0 || Hi !== 32'h2 || Lo !== 32'h0) begin
            miscompares++;
            $display("FAIL madd_second: got busy=%b hi=%h lo=%h want busy=0 hi=2 lo=0", Busy, Hi, Lo);
        end
    endtask

    task automatic test_msub_borrow();
        drive(1'b1, 1'b0, 6'b010001, 64'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 6'b010011, 64'b0, 32'h0);
        step();
        drive(1'b1, 1'b1, 6'b000100, 64'h00000000_00000001, 32'b0);
        step();
        vectors++;
        if (Busy !== 1'b1 || Lo !== 32'hFFFFFFFF || Hi !== 32'h0) begin
            miscompares++;
            $display("FAIL msub_first: got busy=%b hi=%h lo=%h want busy=1 hi=0 lo=ffffffff", Busy, Hi, Lo);
        end
        drive(1'b0, 1'b0, 6'b0, 64'b0, 32'b0);
        step();
        vectors++;
        if (Busy !== 1'b0 || {Hi, Lo} !== 64'hFFFFFFFF_FFFFFFFF) begin
            miscompares++;
            $display("FAIL msub_wrap: got busy=%b hilo=%h want busy=0 hilo=ffffffffffffffff",
                     Busy, {Hi, Lo});
        end
    endtask

    task automatic test_mismatch();
        // MFHI code with ACCEn=1 and MADD code with ACCEn=0 are both no-ops
        drive(1'b1, 1'b1, 6'b010000, 64'h1, 32'h0);
        step();
        drive(1'b1, 1'b0, 6'b000000, 64'h1, 32'h0);
        step();
        vectors++;
        if (ResultValid !== 1'b0 || Busy !== 1'b0 || {Hi, Lo} !== 64'hFFFFFFFF_FFFFFFFF) begin
            miscompares++;
            $display("FAIL func_mismatch: got rv=%b busy=%b hilo=%h want rv=0 busy=0 hilo=ffffffffffffffff",
                     ResultValid, Busy, {Hi, Lo});
        end
    endtask

    task automatic test_back_to_back();
        // {HI,LO}=all ones; add 0x00000001_00000001 -> HI=1, LO=0
        drive(1'b1, 1'b1, 6'b000001, 64'h00000001_00000001, 32'b0);
        step();
        vectors++;
        if (Busy !== 1'b1 || Lo !== 32'h0) begin
            miscompares++;
            $display("FAIL b2b_first: got busy=%b lo=%h want busy=1 lo=0", Busy, Lo);
        end
        drive(1'b1, 1'b0, 6'b010000, 64'h0, 32'b0);    // MFHI held while busy
        step();
        vectors++;
        if (Busy !== 1'b0 || ResultValid !== 1'b0 || Hi !== 32'h1) begin
            miscompares++;
            $display("FAIL b2b_busy_hold: got busy=%b rv=%b hi=%h want busy=0 rv=0 hi=1",
                     Busy, ResultValid, Hi);
        end
        step();
        vectors++;
        if (ResultValid !== 1'b1 || Result !== 32'h1 || Hi !== 32'h1 || Lo !== 32'h0) begin
            miscompares++;
            $display("FAIL b2b_mfhi: got rv=%b res=%h hi=%h lo=%h want rv=1 res=1 hi=1 lo=0",
                     ResultValid, Result, Hi, Lo);
        end
        drive(1'b0, 1'b0, 6'b0, 64'b0, 32'b0);
        step();
        vectors++;
        if (ResultValid !== 1'b0 || Result !== 32'h1) begin
            miscompares++;
            $display("FAIL b2b_result_hold: got rv=%b res=%h want rv=0 res=1", ResultValid, Result);
        end
    endtask

    task automatic test_reset_mid_acc();
        drive(1'b1, 1'b1, 6'b000000, 64'h00000000_00000005, 32'b0);
        step();
        vectors++;
        if (Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midacc_busy: got busy=%b want 1", Busy);
        end
        #2;
        nReset = 1'b1;
        #1;
        vectors++;
        if (Busy !== 1'b0 || ResultValid !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
            miscompares++;
            $display("FAIL midacc_async_reset: got busy=%b rv=%b hi=%h lo=%h want all 0",
                     Busy, ResultValid, Hi, Lo);
        end
        #2;
        nReset = 1'b0;
        drive(1'b1, 1'b1, 6'b000000, 64'h00000002_00000003, 32'b0);
        step();
        drive(1'b0, 1'b0, 6'b0, 64'b0, 32'b0);
        step();
        vectors++;
        if (Busy !== 1'b0 || Hi !== 32'h2 || Lo !== 32'h3) begin
            miscompares++;
            $display("FAIL midacc_restart: got busy=%b hi=%h lo=%h want busy=0 hi=2 lo=3", Busy, Hi, Lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_madd_carry();
        test_msub_borrow();
        test_mismatch();
        test_back_to_back();
        test_reset_mid_acc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish want finish before 20000");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/hilo_acc.md
Name: hilo_acc

Overview:
- HI/LO accumulator register unit; the consumer of the execute-stage 64-bit multiply result and its ACCEn accumulate flag.
- Sits after the first execute stage and holds the architectural HI/LO pair.
- Executes MULT/MULTU writeback, MTHI/MTLO, MFHI/MFLO, and the MADD/MADDU/MSUB/MSUBU accumulate operations.
- Accumulates run as a 2-cycle split-carry add/subtract, with a Busy back-pressure handshake to the pipeline.

Parameters:
- W, 32, data width of HI and LO. The product is 2*W.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous reset, active-high (1 = reset).
- Valid  in  1  operation presented this cycle.
- ACCEn  in  1  1: Func selects the accumulate class. 0: Func selects the HI/LO move/mult class.
- Func  in  6  function code.
- Product  in  2W  64-bit product from the multiplier.
- RsData  in  W  source operand for MTHI/MTLO.
- Busy  out  1  unit is in its second accumulate cycle; the new op is not accepted.
- Result  out  W  MFHI/MFLO read data.
- ResultValid  out  1  Result is valid this cycle.
- Hi  out  W  current HI register.
- Lo  out  W  current LO register.

Behaviour:
- Reset: HI, LO, Result, carry latch and product-high latch = 0. ResultValid = 0, Busy = 0, state = IDLE. Reset is asynchronous and takes effect immediately from any state, including mid-accumulate; the partial result is discarded.
- An op is accepted when Valid=1 and Busy=0. While Busy=1, the inputs are ignored and upstream must hold them stable until Busy=0.
- Move/mult class (ACCEn=0), all single-cycle; state stays IDLE:
  - 011000 MULT and 011001 MULTU: HI<=Product[63:32], LO<=Product[31:0].
  - 010001 MTHI: HI<=RsData.
  - 010011 MTLO: LO<=RsData.
  - 010000 MFHI: Result<=HI, ResultValid<=1 on the next edge.
  - 010010 MFLO: Result<=LO, ResultValid<=1 on the next edge.
  - Read latency is 1 cycle. The value read is the HI/LO value before this edge.
- Accumulate class (ACCEn=1):
  - 000000 MADD and 000001 MADDU: add.
  - 000100 MSUB and 000101 MSUBU: subtract.
  - Signed and unsigned variants behave identically, because Product is already sign-correct and the arithmetic is mod 2^64.
- Accumulate FSM, IDLE -> ADDHI -> IDLE:
  - IDLE, acc op accepted (add): {c,LO} <= LO + Product[31:0]. Latch c, latch Product[63:32], latch the op. Next state ADDHI.
  - IDLE, acc op accepted (subtract): LO <= LO - Product[31:0]. c <= borrow (1 when LO < Product[31:0], unsigned). Next state ADDHI.
  - ADDHI: Busy=1 as a Moore output.
  - ADDHI, add: HI <= HI + Phi + c.
  - ADDHI, subtract: HI <= HI - Phi - c.
  - ADDHI always returns to IDLE; Busy falls after that edge.
  - Net result: {HI,LO} +/- Product, mod 2^64. Latency is 2 cycles, throughput 1 acc op per 2 cycles.
- Hi/Lo outputs show register contents directly: LO updates after the first acc edge, HI after the second.
- ResultValid: 1 for exactly one cycle after an accepted MFHI/MFLO, otherwise 0. Result holds its last value when ResultValid=0.
- Unrecognised Func, ACCEn/Func mismatch, or Valid=0: no state change; ResultValid<=0.
- Wrap-around: all sums and differences are modulo 2^W per half. No overflow flag and no exception.

Test Plan:
- Reset then MFHI, then MFLO -> Result=0x00000000 both times, ResultValid pulses for 1 cycle each; Busy stays 0.
- MULT with Product=0x12345678_9ABCDEF0, then MFHI, then MFLO -> Result=0x12345678, then 0x9ABCDEF0.
- MTLO 0xFFFFFFFF, MTHI 0x00000001, then MADD with Product=0x00000000_00000001:
  - Busy=1 for exactly 1 cycle.
  - LO=0x00000000 after the first edge; HI=0x00000002 after the second (carry propagated).
- HI=0, LO=0, then MSUB with Product=0x00000000_00000001 -> {HI,LO}=0xFFFFFFFF_FFFFFFFF (borrow and wrap-around).
- MADD issued and held with Valid=1, followed by MFHI held while Busy=1:
  - MFHI is accepted only after Busy=0.
  - It returns the post-accumulate HI value.
  - Exactly one accumulate occurs, not two.
- Assert nReset during ADDHI -> Busy=0, HI=LO=0, ResultValid=0 immediately (asynchronous). The next MADD after release starts from {0,0}.
